// File: rtl/bus_pkg.sv
// Shared types and width helpers for the round-robin cache-to-memory bus.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // A memory beat is never wider than one cache block.
  function automatic int data_width(int block_width, int dma_width);
    return ((dma_width > block_width) ? block_width : dma_width) * 32;
  endfunction

  function automatic int pkt_width(int block_width, int dma_width);
    return 33 + data_width(block_width, dma_width);
  endfunction

  function automatic int ptr_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int default_data_width_lp = data_width(16, 8);

  typedef struct packed {
    logic                             we;
    logic [31:0]                      addr;
    logic [default_data_width_lp-1:0] wdata;
  } cb_pkt_s;

endpackage

// File: rtl/bus_rr_arbiter.sv
// Combinational grant: round-robin search from rr_ptr, or fixed lowest-index priority.
module bus_rr_arbiter
  import bus_pkg::*;
#(
  parameter int num_caches_p = 4,
  localparam int ptr_w_lp = ptr_width(num_caches_p)
) (
  input  logic [num_caches_p-1:0] valid,
  input  logic [ptr_w_lp-1:0]     rr_ptr,
  input  logic                    rr_mode,
  output logic                    grant_v,
  output logic [ptr_w_lp-1:0]     grant_idx,
  output logic [num_caches_p-1:0] grant_oh
);

  logic [ptr_w_lp-1:0] cand;

  always_comb begin
    grant_v   = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    cand      = '0;
    for (int i = 0; i < num_caches_p; i++) begin
      cand = rr_mode ? ptr_w_lp'((int'(rr_ptr) + i) % num_caches_p) : ptr_w_lp'(i);
      if (!grant_v && valid[cand]) begin
        grant_v   = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_v) grant_oh[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/bus_rr.sv
// Shared memory bus for num_caches_p caches: one transaction in flight, write-invalidate snoop.
// Handshakes: a cache request transfers on cb_valid_i[g] & cb_yumi_o[g]; a memory request on mem_valid_o & mem_ready_i.
module bus_rr
  import bus_pkg::*;
#(
  parameter int num_caches_p     = 4,
  parameter int block_width_p    = 16,
  parameter int dma_data_width_p = 8,
  parameter int arb_mode_p       = 1,
  localparam int data_w_lp = data_width(block_width_p, dma_data_width_p),
  localparam int pkt_w_lp  = pkt_width(block_width_p, dma_data_width_p),
  localparam int ptr_w_lp  = ptr_width(num_caches_p)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [num_caches_p-1:0]                cb_valid_i,
  output logic [num_caches_p-1:0]                cb_yumi_o,
  input  logic [num_caches_p-1:0][pkt_w_lp-1:0]  cb_pkt_i,
  output logic                                   mem_valid_o,
  input  logic                                   mem_ready_i,
  output logic                                   mem_we_o,
  output logic [31:0]                            mem_addr_o,
  output logic [data_w_lp-1:0]                   mem_wdata_o,
  input  logic                                   mem_valid_i,
  input  logic [data_w_lp-1:0]                   mem_data_i,
  output logic [num_caches_p-1:0]                cb_valid_o,
  output logic [data_w_lp-1:0]                   cb_data_o,
  output logic                                   snoop_valid_o,
  output logic [31:0]                            snoop_addr_o,
  output logic [num_caches_p-1:0]                snoop_mask_o,
  output state_e                                 state_o
);

  state_e                state_q, state_d;
  logic [ptr_w_lp-1:0]   rr_ptr_q, rr_next, gnt_q, grant_idx;
  logic                  grant_v, we_q;
  logic [num_caches_p-1:0] grant_oh;
  logic [31:0]           addr_q;
  logic [data_w_lp-1:0]  wdata_q, data_q;
  logic [pkt_w_lp-1:0]   sel_pkt;

  bus_rr_arbiter #(.num_caches_p(num_caches_p)) u_arb (
    .valid     (cb_valid_i),
    .rr_ptr    (rr_ptr_q),
    .rr_mode   (arb_mode_p == 1),
    .grant_v   (grant_v),
    .grant_idx (grant_idx),
    .grant_oh  (grant_oh)
  );

  assign sel_pkt   = cb_pkt_i[grant_idx];
  assign rr_next   = (int'(grant_idx) == num_caches_p - 1) ? '0 : grant_idx + 1'b1;
  assign cb_data_o = data_q;
  assign state_o   = state_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && grant_v) begin
        we_q    <= sel_pkt[pkt_w_lp-1];
        addr_q  <= sel_pkt[pkt_w_lp-2 -: 32];
        wdata_q <= sel_pkt[data_w_lp-1:0];
        gnt_q   <= grant_idx;
        if (arb_mode_p == 1) rr_ptr_q <= rr_next;
      end
      // Write completions carry no data, so the last read result stays visible.
      if (state_q == WAIT && mem_valid_i && !we_q) data_q <= mem_data_i;
    end
  end

  always_comb begin
    state_d       = state_q;
    cb_yumi_o     = '0;
    mem_valid_o   = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    cb_valid_o    = '0;
    snoop_valid_o = 1'b0;
    snoop_addr_o  = '0;
    snoop_mask_o  = '0;
    if (!reset_i) begin
      case (state_q)
        IDLE: begin
          if (grant_v) begin
            cb_yumi_o = grant_oh;
            state_d   = ISSUE;
          end
        end
        ISSUE: begin
          mem_valid_o = 1'b1;
          mem_we_o    = we_q;
          mem_addr_o  = addr_q;
          mem_wdata_o = wdata_q;
          if (mem_ready_i) state_d = WAIT;
        end
        WAIT: begin
          if (mem_valid_i) state_d = RESP;
        end
        RESP: begin
          cb_valid_o[gnt_q] = 1'b1;
          if (we_q) begin
            snoop_valid_o = 1'b1;
            snoop_addr_o  = addr_q;
            if (num_caches_p > 1) begin
              snoop_mask_o        = '1;
              snoop_mask_o[gnt_q] = 1'b0;
            end
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_rr.sv
// Bench for bus_rr: round-robin and fixed-priority instances share one behavioural memory model.
module tb_bus_rr;
  import bus_pkg::*;

  localparam int rw_lp = 297;

  logic clk = 1'b0;
  logic reset_i = 1'b1;

  logic [3:0]         cb_valid_i [2];
  logic [3:0]         cb_yumi_o [2];
  logic [3:0][288:0]  cb_pkt_i [2];
  logic               mem_valid_o [2];
  logic               mem_ready_i [2];
  logic               mem_we_o [2];
  logic [31:0]        mem_addr_o [2];
  logic [255:0]       mem_wdata_o [2];
  logic               mem_valid_i [2];
  logic [255:0]       mem_data_i [2];
  logic [3:0]         cb_valid_o [2];
  logic [255:0]       cb_data_o [2];
  logic               snoop_valid_o [2];
  logic [31:0]        snoop_addr_o [2];
  logic [3:0]         snoop_mask_o [2];
  state_e             state_o [2];

  logic [rw_lp-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  int ready_delay = 0;
  int resp_latency = 3;
  bit model_en = 1'b1;
  int wait_cnt [2];
  int lat_cnt [2];
  bit busy [2];
  bit cap_we [2];
  logic [31:0] cap_addr [2];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    bus_rr #(
      .num_caches_p(4), .block_width_p(16), .dma_data_width_p(8), .arb_mode_p((k == 0) ? 1 : 0)
    ) u_dut (
      .clk_i(clk), .reset_i(reset_i),
      .cb_valid_i(cb_valid_i[k]), .cb_yumi_o(cb_yumi_o[k]), .cb_pkt_i(cb_pkt_i[k]),
      .mem_valid_o(mem_valid_o[k]), .mem_ready_i(mem_ready_i[k]), .mem_we_o(mem_we_o[k]),
      .mem_addr_o(mem_addr_o[k]), .mem_wdata_o(mem_wdata_o[k]),
      .mem_valid_i(mem_valid_i[k]), .mem_data_i(mem_data_i[k]),
      .cb_valid_o(cb_valid_o[k]), .cb_data_o(cb_data_o[k]),
      .snoop_valid_o(snoop_valid_o[k]), .snoop_addr_o(snoop_addr_o[k]), .snoop_mask_o(snoop_mask_o[k]),
      .state_o(state_o[k])
    );
  end

  function automatic logic [255:0] mem_word(logic [31:0] a);
    return {8{32'hA5A5_A5A5 ^ (a - 32'h40)}};
  endfunction

  function automatic logic [rw_lp-1:0] pack_resp(logic [3:0] v, logic s, logic [31:0] sa,
                                                 logic [3:0] sm, logic [255:0] d);
    return {v, s, sa, sm, d};
  endfunction

  // Memory: accepts after ready_delay stalled cycles, completes resp_latency cycles later.
  always @(negedge clk) begin
    if (model_en) begin
      for (int k = 0; k < 2; k++) begin
        mem_ready_i[k] = 1'b0;
        mem_valid_i[k] = 1'b0;
        if (reset_i) begin
          busy[k] = 1'b0;
          wait_cnt[k] = 0;
        end else if (busy[k]) begin
          if (lat_cnt[k] == 0) begin
            mem_valid_i[k] = 1'b1;
            mem_data_i[k] = cap_we[k] ? {8{$urandom}} : mem_word(cap_addr[k]);
            busy[k] = 1'b0;
          end else lat_cnt[k]--;
        end else if (mem_valid_o[k]) begin
          if (wait_cnt[k] == ready_delay) begin
            mem_ready_i[k] = 1'b1;
            busy[k] = 1'b1;
            lat_cnt[k] = resp_latency - 1;
            cap_addr[k] = mem_addr_o[k];
            cap_we[k] = mem_we_o[k];
            wait_cnt[k] = 0;
          end else wait_cnt[k]++;
        end
      end
    end
  end

  task automatic do_reset();
    reset_i = 1'b1;
    cb_valid_i[0] = '0;
    cb_valid_i[1] = '0;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    exp_q.delete();
  endtask

  task automatic set_pkt(input int k, input int c, input bit we, input logic [31:0] a,
                         input logic [255:0] wd);
    cb_pkt_s p;
    p.we = we;
    p.addr = a;
    p.wdata = wd;
    cb_pkt_i[k][c] = p;
  endtask

  // Raises one request and drops it at the negedge right after the granting edge.
  task automatic drive_req(input int k, input int c, output bit got);
    got = 1'b0;
    @(negedge clk);
    cb_valid_i[k][c] = 1'b1;
    for (int t = 0; t < 50 && !got; t++) begin
      #1;
      if (cb_yumi_o[k][c]) got = 1'b1;
      @(negedge clk);
    end
    cb_valid_i[k][c] = 1'b0;
  endtask

  task automatic wait_resp(input int k, output bit got);
    got = 1'b0;
    for (int t = 0; t < 60 && !got; t++) begin
      @(negedge clk);
      #1;
      if (cb_valid_o[k] != '0) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if (state_o[0] !== IDLE || state_o[1] !== IDLE) $display("FAIL reset_state: got %0d/%0d want 0/0", state_o[0], state_o[1]);
    else n_pass++;
    n_checks++;
    if ({cb_yumi_o[0], mem_valid_o[0], cb_valid_o[0], snoop_valid_o[0], snoop_mask_o[0]} !== 14'h0)
      $display("FAIL reset_ctrl: yumi=%b memv=%b cbv=%b snv=%b mask=%b want all 0", cb_yumi_o[0], mem_valid_o[0], cb_valid_o[0], snoop_valid_o[0], snoop_mask_o[0]);
    else n_pass++;
    n_checks++;
    if (cb_data_o[0] !== 256'h0) $display("FAIL reset_data: got %h want 0", cb_data_o[0]);
    else n_pass++;
  endtask

  task automatic test_single_read();
    bit got;
    logic [rw_lp-1:0] obs, expv;
    do_reset();
    set_pkt(0, 0, 1'b0, 32'h40, 256'h0);
    exp_q.push_back(pack_resp(4'b0001, 1'b0, 32'h0, 4'h0, {32{8'hA5}}));
    drive_req(0, 0, got);
    n_checks++;
    if (!got) $display("FAIL single_yumi: cache 0 not granted want grant");
    else n_pass++;
    #1;
    n_checks++;
    if ({mem_valid_o[0], mem_we_o[0], mem_addr_o[0]} !== {1'b1, 1'b0, 32'h40})
      $display("FAIL single_issue: got v=%b we=%b addr=%h want v=1 we=0 addr=40", mem_valid_o[0], mem_we_o[0], mem_addr_o[0]);
    else n_pass++;
    wait_resp(0, got);
    n_checks++;
    obs = {cb_valid_o[0], snoop_valid_o[0], snoop_addr_o[0], snoop_mask_o[0], cb_data_o[0]};
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (!got) $display("FAIL single_resp: no response within budget");
    else if (obs !== expv) $display("FAIL single_resp: got %h want %h", obs, expv);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if (cb_valid_o[0] !== 4'h0 || snoop_valid_o[0] !== 1'b0) $display("FAIL single_pulse_len: cbv=%b snv=%b want 0", cb_valid_o[0], snoop_valid_o[0]);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    bit got;
    logic [rw_lp-1:0] obs, expv;
    do_reset();
    for (int c = 0; c < 4; c++) set_pkt(0, c, 1'b0, 32'h200 + 32'(c * 16), 256'h0);
    for (int t = 0; t < 8; t++)
      exp_q.push_back(pack_resp(4'b0001 << (t % 4), 1'b0, 32'h0, 4'h0, mem_word(32'h200 + 32'((t % 4) * 16))));
    @(negedge clk);
    cb_valid_i[0] = 4'hF;
    for (int t = 0; t < 8; t++) begin
      wait_resp(0, got);
      n_checks++;
      obs = {cb_valid_o[0], snoop_valid_o[0], snoop_addr_o[0], snoop_mask_o[0], cb_data_o[0]};
      expv = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      if (!got) $display("FAIL rr_resp%0d: no response within budget", t);
      else if (obs !== expv) $display("FAIL rr_resp%0d: got cbv=%b data=%h want cbv=%b data=%h", t, obs[296:293], obs[255:0], expv[296:293], expv[255:0]);
      else n_pass++;
    end
    cb_valid_i[0] = 4'h0;
  endtask

  task automatic test_fixed_priority();
    int g3 = 0;
    int nresp = 0;
    logic [rw_lp-1:0] obs, expv;
    do_reset();
    for (int c = 0; c < 4; c++) set_pkt(1, c, 1'b0, 32'h200 + 32'(c * 16), 256'h0);
    for (int t = 0; t < 4; t++) exp_q.push_back(pack_resp(4'b0010, 1'b0, 32'h0, 4'h0, mem_word(32'h210)));
    @(negedge clk);
    cb_valid_i[1] = 4'b1010;
    for (int t = 0; t < 200 && nresp < 4; t++) begin
      #1;
      if (cb_yumi_o[1][3]) g3++;
      if (cb_valid_o[1] != '0) begin
        nresp++;
        n_checks++;
        obs = {cb_valid_o[1], snoop_valid_o[1], snoop_addr_o[1], snoop_mask_o[1], cb_data_o[1]};
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if (obs !== expv) $display("FAIL fixed_resp%0d: got cbv=%b data=%h want cbv=%b data=%h", nresp, obs[296:293], obs[255:0], expv[296:293], expv[255:0]);
        else n_pass++;
      end
      @(negedge clk);
    end
    cb_valid_i[1] = 4'h0;
    n_checks++;
    if (nresp != 4) $display("FAIL fixed_count: got %0d responses want 4", nresp);
    else n_pass++;
    n_checks++;
    if (g3 != 0) $display("FAIL fixed_starve: cache 3 granted %0d times want 0", g3);
    else n_pass++;
  endtask

  task automatic test_write_snoop();
    bit got;
    logic [255:0] wd;
    logic [rw_lp-1:0] obs, expv;
    do_reset();
    set_pkt(0, 0, 1'b0, 32'h40, 256'h0);
    exp_q.push_back(pack_resp(4'b0001, 1'b0, 32'h0, 4'h0, {32{8'hA5}}));
    drive_req(0, 0, got);
    wait_resp(0, got);
    n_checks++;
    obs = {cb_valid_o[0], snoop_valid_o[0], snoop_addr_o[0], snoop_mask_o[0], cb_data_o[0]};
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (!got) $display("FAIL wr_pre_read: no response within budget");
    else if (obs !== expv) $display("FAIL wr_pre_read: got %h want %h", obs, expv);
    else n_pass++;
    wd = {8{$urandom}};
    set_pkt(0, 2, 1'b1, 32'h100, wd);
    exp_q.push_back(pack_resp(4'b0100, 1'b1, 32'h100, 4'b1011, {32{8'hA5}}));
    drive_req(0, 2, got);
    #1;
    n_checks++;
    if ({mem_valid_o[0], mem_we_o[0], mem_addr_o[0], mem_wdata_o[0]} !== {1'b1, 1'b1, 32'h100, wd})
      $display("FAIL wr_issue: got v=%b we=%b addr=%h wdata=%h want v=1 we=1 addr=100 wdata=%h", mem_valid_o[0], mem_we_o[0], mem_addr_o[0], mem_wdata_o[0], wd);
    else n_pass++;
    wait_resp(0, got);
    n_checks++;
    obs = {cb_valid_o[0], snoop_valid_o[0], snoop_addr_o[0], snoop_mask_o[0], cb_data_o[0]};
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (!got) $display("FAIL wr_resp: no response within budget");
    else if (obs !== expv) $display("FAIL wr_resp: got cbv=%b snv=%b sna=%h mask=%b data=%h want %h", obs[296:293], obs[292], obs[291:260], obs[259:256], obs[255:0], expv);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if ({snoop_valid_o[0], snoop_addr_o[0], snoop_mask_o[0]} !== 37'h0)
      $display("FAIL wr_snoop_clear: snv=%b sna=%h mask=%b want 0", snoop_valid_o[0], snoop_addr_o[0], snoop_mask_o[0]);
    else n_pass++;
  endtask

  task automatic test_issue_stall();
    bit got;
    int stable = 0;
    int rdy_at = 0;
    logic [255:0] wd;
    logic [rw_lp-1:0] obs, expv;
    do_reset();
    ready_delay = 5;
    wd = {8{$urandom}};
    set_pkt(0, 3, 1'b0, 32'h80, wd);
    exp_q.push_back(pack_resp(4'b1000, 1'b0, 32'h0, 4'h0, mem_word(32'h80)));
    drive_req(0, 3, got);
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      if (state_o[0] == ISSUE && mem_valid_o[0] && !mem_we_o[0] && mem_addr_o[0] == 32'h80 && mem_wdata_o[0] == wd) stable++;
      if (mem_ready_i[0] && rdy_at == 0) rdy_at = c;
    end
    n_checks++;
    if (stable != 6) $display("FAIL stall_stable: got %0d stable issue cycles want 6", stable);
    else n_pass++;
    n_checks++;
    if (rdy_at != 6) $display("FAIL stall_handshake: ready on cycle %0d want 6", rdy_at);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if (state_o[0] !== WAIT) $display("FAIL stall_to_wait: got state %0d want %0d", state_o[0], WAIT);
    else n_pass++;
    wait_resp(0, got);
    n_checks++;
    obs = {cb_valid_o[0], snoop_valid_o[0], snoop_addr_o[0], snoop_mask_o[0], cb_data_o[0]};
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (!got) $display("FAIL stall_resp: no response within budget");
    else if (obs !== expv) $display("FAIL stall_resp: got %h want %h", obs, expv);
    else n_pass++;
    ready_delay = 0;
  endtask

  task automatic test_withdraw();
    bit got;
    int y0 = 0;
    int idle_cnt = 0;
    logic [rw_lp-1:0] obs, expv;
    do_reset();
    resp_latency = 6;
    set_pkt(0, 1, 1'b0, 32'h140, 256'h0);
    set_pkt(0, 0, 1'b0, 32'h40, 256'h0);
    exp_q.push_back(pack_resp(4'b0010, 1'b0, 32'h0, 4'h0, mem_word(32'h140)));
    drive_req(0, 1, got);
    cb_valid_i[0][0] = 1'b1;
    for (int t = 0; t < 3; t++) begin
      #1;
      if (cb_yumi_o[0][0]) y0++;
      @(negedge clk);
    end
    cb_valid_i[0][0] = 1'b0;
    wait_resp(0, got);
    n_checks++;
    obs = {cb_valid_o[0], snoop_valid_o[0], snoop_addr_o[0], snoop_mask_o[0], cb_data_o[0]};
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (!got) $display("FAIL withdraw_resp: no response within budget");
    else if (obs !== expv) $display("FAIL withdraw_resp: got %h want %h", obs, expv);
    else n_pass++;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      #1;
      if (cb_yumi_o[0][0]) y0++;
      if (state_o[0] == IDLE) idle_cnt++;
    end
    n_checks++;
    if (y0 != 0 || idle_cnt != 6) $display("FAIL withdraw_grant: yumi0=%0d idle=%0d want 0 and 6", y0, idle_cnt);
    else n_pass++;
    resp_latency = 3;
  endtask

  task automatic test_reset_mid();
    bit got;
    bit in_wait = 1'b0;
    int late = 0;
    logic [rw_lp-1:0] obs, expv;
    do_reset();
    set_pkt(0, 0, 1'b0, 32'h40, 256'h0);
    exp_q.push_back(pack_resp(4'b0001, 1'b0, 32'h0, 4'h0, {32{8'hA5}}));
    drive_req(0, 0, got);
    wait_resp(0, got);
    n_checks++;
    obs = {cb_valid_o[0], snoop_valid_o[0], snoop_addr_o[0], snoop_mask_o[0], cb_data_o[0]};
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (!got) $display("FAIL rstmid_pre_read: no response within budget");
    else if (obs !== expv) $display("FAIL rstmid_pre_read: got %h want %h", obs, expv);
    else n_pass++;
    resp_latency = 10;
    set_pkt(0, 1, 1'b0, 32'h180, 256'h0);
    drive_req(0, 1, got);
    for (int t = 0; t < 20 && !in_wait; t++) begin
      @(negedge clk);
      #1;
      if (state_o[0] == WAIT) in_wait = 1'b1;
    end
    n_checks++;
    if (!in_wait) $display("FAIL rstmid_reach_wait: state %0d want %0d", state_o[0], WAIT);
    else n_pass++;
    model_en = 1'b0;
    busy[0] = 1'b0;
    wait_cnt[0] = 0;
    mem_ready_i[0] = 1'b0;
    mem_valid_i[0] = 1'b0;
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    n_checks++;
    if (state_o[0] !== IDLE) $display("FAIL rstmid_state: got %0d want %0d", state_o[0], IDLE);
    else n_pass++;
    n_checks++;
    if ({cb_yumi_o[0], mem_valid_o[0], cb_valid_o[0], snoop_valid_o[0], snoop_addr_o[0], snoop_mask_o[0], cb_data_o[0]} !== '0)
      $display("FAIL rstmid_outputs: yumi=%b memv=%b cbv=%b snv=%b data=%h want all 0", cb_yumi_o[0], mem_valid_o[0], cb_valid_o[0], snoop_valid_o[0], cb_data_o[0]);
    else n_pass++;
    @(negedge clk);
    mem_valid_i[0] = 1'b1;
    mem_data_i[0] = mem_word(32'h180);
    @(negedge clk);
    mem_valid_i[0] = 1'b0;
    for (int t = 0; t < 5; t++) begin
      #1;
      if (cb_valid_o[0] != '0 || cb_data_o[0] != '0) late++;
      @(negedge clk);
    end
    n_checks++;
    if (late != 0) $display("FAIL rstmid_late_resp: %0d cycles with response activity want 0", late);
    else n_pass++;
    model_en = 1'b1;
    resp_latency = 3;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      cb_valid_i[k] = '0;
      cb_pkt_i[k] = '0;
      mem_ready_i[k] = 1'b0;
      mem_valid_i[k] = 1'b0;
      mem_data_i[k] = '0;
      busy[k] = 1'b0;
      wait_cnt[k] = 0;
      lat_cnt[k] = 0;
    end
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_write_snoop();
    test_issue_stall();
    test_withdraw();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, %0d/%0d passed so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
